// File: rtl/switch_ctrl.sv
// switch_ctrl: conditions raw board switches for the clock counter.
// Each switch is synchronised, debounced and turned into a stable level plus
// one-cycle rise/fall pulses. Switch 0 rising toggles the counter enable and
// switch 1 rising issues a one-cycle counter clear.
// Optional build macro SWITCH_CTRL_SYNC3_EN: lengthens the synchroniser from
// 2 to 3 flops, adding one edge to every latency.
module switch_ctrl #(
    parameter int NUM_SW          = 2,
    parameter int DEBOUNCE_CYCLES = 1250000,
    parameter int CNT_W           = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] switches_in,
    output logic [NUM_SW-1:0] sw_stable,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              cnt_en,
    output logic              cnt_clr
);

    // Terminal count: a pending level is accepted on its DEBOUNCE_CYCLES-th
    // consecutive edge, i.e. when the counter already holds DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0] r_sync_p0;
    logic [NUM_SW-1:0] r_sync_p1;
`ifdef SWITCH_CTRL_SYNC3_EN
    logic [NUM_SW-1:0] r_sync_p2;
`endif
    logic [NUM_SW-1:0] w_sync_out;

    logic [CNT_W-1:0]  r_cnt [NUM_SW];
    logic [NUM_SW-1:0] r_stable;
    logic [NUM_SW-1:0] r_rise;
    logic [NUM_SW-1:0] r_fall;
    logic              r_en;
    logic              r_clr;

    logic [NUM_SW-1:0] w_pending;
    logic [NUM_SW-1:0] w_terminal;

    // --- Stage: metastability synchroniser (raw pins -> fabric clock) ---
    // Shift each raw switch level through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
`ifdef SWITCH_CTRL_SYNC3_EN
            r_sync_p2 <= '0;
`endif
        end else begin
            r_sync_p0 <= switches_in;
            r_sync_p1 <= r_sync_p0;
`ifdef SWITCH_CTRL_SYNC3_EN
            r_sync_p2 <= r_sync_p1;
`endif
        end
    end

    // Only the last synchroniser flop is allowed to feed the debounce logic.
`ifdef SWITCH_CTRL_SYNC3_EN
    assign w_sync_out = r_sync_p2;
`else
    assign w_sync_out = r_sync_p1;
`endif

    // --- Stage: debounce (per-bit STABLE / PENDING decision) ---
    // A bit is PENDING while its synchronised level disagrees with the
    // accepted level; it is accepted once the counter reaches terminal count.
    always_comb begin
        w_pending  = w_sync_out ^ r_stable;
        w_terminal = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            w_terminal[i] = w_pending[i] && (r_cnt[i] == TERM_CNT);
        end
    end

    // Advance the debounce counters, accept new levels and emit edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                // Pulses default low so they can never last more than a cycle.
                r_rise[i] <= 1'b0;
                r_fall[i] <= 1'b0;
                if (w_terminal[i]) begin
                    r_stable[i] <= w_sync_out[i];
                    r_rise[i]   <= w_sync_out[i];
                    r_fall[i]   <= ~w_sync_out[i];
                    r_cnt[i]    <= '0;
                end else if (w_pending[i]) begin
                    // Capped by the terminal compare above, so never wraps.
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else begin
                    // Glitch returned to the accepted level: restart from 0.
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // --- Stage: counter control mapping ---
    // Switch 0 press toggles the enable; switch 1 press becomes a clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en  <= 1'b0;
            r_clr <= 1'b0;
        end else begin
            r_en  <= r_en ^ r_rise[0];
            r_clr <= r_rise[1];
        end
    end

    assign sw_stable = r_stable;
    assign sw_rise   = r_rise;
    assign sw_fall   = r_fall;
    assign cnt_en    = r_en;
    assign cnt_clr   = r_clr;

endmodule

// File: tb/tb_switch_ctrl.sv
// Self-checking bench for switch_ctrl (DEBOUNCE_CYCLES=4, NUM_SW=2).
// Expected values come from a reference model that keeps the stream of
// delayed switch samples and accepts a new level once the last
// DEBOUNCE_CYCLES delayed samples all disagree with the accepted level.
module tb_switch_ctrl;

    localparam int DC  = 4;
    localparam int NSW = 2;
    localparam int CW  = 3;
`ifdef SWITCH_CTRL_SYNC3_EN
    localparam int SYNC_N = 3;
`else
    localparam int SYNC_N = 2;
`endif
    // Edge (after a held change) at which sw_stable / pulses update.
    localparam int LAT = SYNC_N + DC;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NSW-1:0] switches_in = '0;
    logic [NSW-1:0] sw_stable;
    logic [NSW-1:0] sw_rise;
    logic [NSW-1:0] sw_fall;
    logic           cnt_en;
    logic           cnt_clr;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [1:0] m_stable, m_rise, m_fall;
    logic       m_en, m_clr;
    logic [1:0] rq[$];   // raw samples still inside the synchroniser delay
    logic [1:0] dl[$];   // last DC delayed samples seen by the debouncer

    switch_ctrl #(
        .NUM_SW         (NSW),
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .switches_in(switches_in),
        .sw_stable  (sw_stable),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_stable = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_en     = 1'b0;
        m_clr    = 1'b0;
        rq.delete();
        for (int k = 0; k < SYNC_N; k++) rq.push_back(2'b00);
        dl.delete();
    endtask

    task automatic model_step();
        logic [1:0] d;
        logic [1:0] nrise;
        logic [1:0] nfall;
        logic       all_diff;
        rq.push_back(switches_in);
        d = rq[0];
        void'(rq.pop_front());
        dl.push_back(d);
        if (dl.size() > DC) void'(dl.pop_front());
        m_clr = m_rise[1];
        m_en  = m_en ^ m_rise[0];
        nrise = '0;
        nfall = '0;
        for (int i = 0; i < 2; i++) begin
            all_diff = (dl.size() == DC);
            for (int k = 0; k < dl.size(); k++) begin
                if (dl[k][i] == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_stable[i] = ~m_stable[i];
                nrise[i]    = m_stable[i];
                nfall[i]    = ~m_stable[i];
            end
        end
        m_rise = nrise;
        m_fall = nfall;
    endtask

    // One clock edge: advance the model, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
    endtask

    // Bring DUT and model to a known idle state with all switches low.
    task automatic apply_reset();
        switches_in = '0;
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 2; k++) tick();
    endtask

    task automatic test_reset();
        switches_in = 2'b11;
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) tick();
        total++;
        if ({sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr} !== 8'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b",
                     {sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr}, 8'b0);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= LAT + 3; e++) begin
            tick();
            total++;
            if ({sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr} !==
                {m_stable, m_rise, m_fall, m_en, m_clr}) begin
                bad++;
                $display("FAIL reset_model edge=%0d got=%b want=%b", e,
                         {sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr},
                         {m_stable, m_rise, m_fall, m_en, m_clr});
            end
            if (e == LAT - 1) begin
                total++;
                if (sw_stable !== 2'b00) begin
                    bad++;
                    $display("FAIL reset_early_stable got=%b want=00", sw_stable);
                end
            end
            if (e == LAT) begin
                total++;
                if ({sw_stable, sw_rise} !== 4'b1111) begin
                    bad++;
                    $display("FAIL reset_release_rise got=%b want=1111", {sw_stable, sw_rise});
                end
            end
            if (e == LAT + 1) begin
                total++;
                if ({cnt_en, cnt_clr, sw_rise} !== 4'b1100) begin
                    bad++;
                    $display("FAIL reset_release_ctrl got=%b want=1100", {cnt_en, cnt_clr, sw_rise});
                end
            end
            if (e == LAT + 2) begin
                total++;
                if ({cnt_en, cnt_clr} !== 2'b10) begin
                    bad++;
                    $display("FAIL reset_clr_width got=%b want=10", {cnt_en, cnt_clr});
                end
            end
        end
    endtask

    task automatic test_glitch();
        int rises;
        apply_reset();
        // High for DC-1 cycles: must be rejected.
        switches_in = 2'b01;
        for (int k = 0; k < DC - 1; k++) tick();
        switches_in = 2'b00;
        for (int e = 1; e <= LAT + 4; e++) begin
            tick();
            total++;
            if ({sw_stable, sw_rise, sw_fall, cnt_en} !== 7'b0) begin
                bad++;
                $display("FAIL glitch_reject edge=%0d got=%b want=%b", e,
                         {sw_stable, sw_rise, sw_fall, cnt_en}, 7'b0);
            end
        end
        // High for exactly DC cycles: just long enough to be accepted.
        rises = 0;
        switches_in = 2'b01;
        for (int k = 0; k < DC; k++) begin
            tick();
            if (sw_rise[0]) rises++;
        end
        switches_in = 2'b00;
        for (int e = 1; e <= LAT + 6; e++) begin
            tick();
            if (sw_rise[0]) rises++;
            total++;
            if ({sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr} !==
                {m_stable, m_rise, m_fall, m_en, m_clr}) begin
                bad++;
                $display("FAIL glitch_model edge=%0d got=%b want=%b", e,
                         {sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr},
                         {m_stable, m_rise, m_fall, m_en, m_clr});
            end
        end
        total++;
        if (rises !== 1) begin
            bad++;
            $display("FAIL glitch_min_hold rises=%0d want=1", rises);
        end
    endtask

    task automatic test_enable_toggle();
        logic [1:0] seq [3];
        logic       en_after [3];
        seq[0] = 2'b01; en_after[0] = 1'b1;
        seq[1] = 2'b00; en_after[1] = 1'b1;
        seq[2] = 2'b01; en_after[2] = 1'b0;
        apply_reset();
        for (int s = 0; s < 3; s++) begin
            switches_in = seq[s];
            for (int e = 1; e <= LAT + 4; e++) begin
                tick();
                total++;
                if ({sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr} !==
                    {m_stable, m_rise, m_fall, m_en, m_clr}) begin
                    bad++;
                    $display("FAIL toggle_model step=%0d edge=%0d got=%b want=%b", s, e,
                             {sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr},
                             {m_stable, m_rise, m_fall, m_en, m_clr});
                end
                if (e == LAT) begin
                    total++;
                    if ({sw_rise[0], sw_fall[0]} !== {seq[s][0], ~seq[s][0]}) begin
                        bad++;
                        $display("FAIL toggle_pulse step=%0d got=%b want=%b", s,
                                 {sw_rise[0], sw_fall[0]}, {seq[s][0], ~seq[s][0]});
                    end
                end
                if (e == LAT + 2) begin
                    total++;
                    if (cnt_en !== en_after[s]) begin
                        bad++;
                        $display("FAIL toggle_en step=%0d got=%b want=%b", s, cnt_en, en_after[s]);
                    end
                end
            end
        end
        switches_in = 2'b00;
        for (int k = 0; k < LAT + 2; k++) tick();
    endtask

    task automatic test_clear();
        int pulses;
        int pulse_edge;
        int en_bad;
        apply_reset();
        // Turn the enable on first so "unchanged" means staying high.
        switches_in = 2'b01;
        for (int k = 0; k < LAT + 2; k++) tick();
        switches_in = 2'b00;
        for (int k = 0; k < LAT + 2; k++) tick();
        pulses = 0;
        pulse_edge = -1;
        en_bad = 0;
        switches_in = 2'b10;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (cnt_clr) begin
                pulses++;
                if (pulse_edge < 0) pulse_edge = e;
            end
            if (cnt_en !== 1'b1) en_bad++;
            total++;
            if ({sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr} !==
                {m_stable, m_rise, m_fall, m_en, m_clr}) begin
                bad++;
                $display("FAIL clear_model edge=%0d got=%b want=%b", e,
                         {sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr},
                         {m_stable, m_rise, m_fall, m_en, m_clr});
            end
        end
        total++;
        if (pulses !== 1 || pulse_edge !== LAT + 1) begin
            bad++;
            $display("FAIL clear_pulse count=%0d edge=%0d want count=1 edge=%0d",
                     pulses, pulse_edge, LAT + 1);
        end
        total++;
        if (en_bad !== 0) begin
            bad++;
            $display("FAIL clear_keeps_en cycles_low=%0d want=0", en_bad);
        end
        switches_in = 2'b00;
        for (int k = 0; k < LAT + 2; k++) tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        switches_in = 2'b01;
        for (int e = 1; e <= 3; e++) begin
            tick();
            total++;
            if (sw_rise !== 2'b00) begin
                bad++;
                $display("FAIL midrst_pre edge=%0d got=%b want=00", e, sw_rise);
            end
        end
        rst_n = 1'b0;
        model_reset();
        tick();
        total++;
        if ({sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr} !== 8'b0) begin
            bad++;
            $display("FAIL midrst_in_reset got=%b want=%b",
                     {sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr}, 8'b0);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= LAT + 2; e++) begin
            tick();
            total++;
            if ({sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr} !==
                {m_stable, m_rise, m_fall, m_en, m_clr}) begin
                bad++;
                $display("FAIL midrst_model edge=%0d got=%b want=%b", e,
                         {sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr},
                         {m_stable, m_rise, m_fall, m_en, m_clr});
            end
            if (e == LAT) begin
                total++;
                if (sw_rise !== 2'b01) begin
                    bad++;
                    $display("FAIL midrst_rise got=%b want=01", sw_rise);
                end
            end
            if (e == LAT + 1) begin
                total++;
                if (cnt_en !== 1'b1) begin
                    bad++;
                    $display("FAIL midrst_en got=%b want=1", cnt_en);
                end
            end
        end
        switches_in = 2'b00;
        for (int k = 0; k < LAT + 2; k++) tick();
    endtask

    task automatic test_random();
        logic [1:0] v;
        int         hold;
        apply_reset();
        for (int seg = 0; seg < 300; seg++) begin
            v    = 2'($urandom_range(0, 3));
            hold = int'($urandom_range(1, 2 * DC + 2));
            switches_in = v;
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            for (int k = 0; k < hold; k++) begin
                tick();
                rst_n = 1'b1;
                total++;
                if ({sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr} !==
                    {m_stable, m_rise, m_fall, m_en, m_clr}) begin
                    bad++;
                    $display("FAIL random_model seg=%0d got=%b want=%b", seg,
                             {sw_stable, sw_rise, sw_fall, cnt_en, cnt_clr},
                             {m_stable, m_rise, m_fall, m_en, m_clr});
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_glitch();
        test_enable_toggle();
        test_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
